inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the WISC-SP20 CPU. It owns the PC, issues word reads to instruction memory, and hands each 16-bit instruction to the control decoder over a valid/ready handshake, together with its incremented PC. It also accepts PC redirects from branch/jump resolution and stops fetching permanently after handing off a HALT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  16  read address, equal to the current PC.
- imem_rdata  in  16  read data, valid when imem_ready=1.
- imem_ready  in  1  response strobe; valid only while imem_req=1.
- inst  out  16  instruction presented to the decoder.
- inst_pc2  out  16  PC of `inst` plus 2.
- inst_valid  out  1  `inst` and `inst_pc2` are valid.
- inst_ready  in  1  decoder accepts `inst` this cycle.
- redirect  in  1  flush and load a new PC.
- redirect_pc  in  16  target PC for `redirect`.
- halted  out  1  HALT has been handed off; fetch is stopped.

## Operation
- States: IDLE, REQ, HOLD, HALT.
- Reset:
  - PC=RESET_PC, state IDLE.
  - imem_req=0, inst_valid=0, inst=16'h0800 (NOP), inst_pc2=0, halted=0.
- IDLE goes to REQ on the first clock after reset is released.
- REQ:
  - imem_req=1 and imem_addr=PC.
  - The address stays stable until imem_ready, except on redirect.
  - On imem_ready: register imem_rdata into `inst` and PC+2 into `inst_pc2`, set PC=PC+2, go to HOLD.
- HOLD:
  - inst_valid=1 and imem_req=0; `inst` and `inst_pc2` are held stable.
  - On inst_valid&&inst_ready: if inst[15:11]==5'b00000 (HALT), go to HALT; otherwise go to REQ.
- HALT:
  - imem_req=0, inst_valid=0, halted=1.
  - Only reset exits this state; redirect is ignored.
- Redirect has priority over every event except reset, in all states except HALT:
  - PC=redirect_pc, inst_valid drops next cycle, next state is REQ.
  - A response arriving in the same cycle is discarded.
  - A handshake in the same cycle is void, so a HALT being held is discarded as wrong-path and does not stop fetch.
  - A redirect in IDLE loads the PC; fetch starts from redirect_pc.
- PC arithmetic is 16-bit unsigned and wraps: 16'hFFFE+2 gives 16'h0000, for both PC and inst_pc2.
- The memory may see its address change while a request is pending (on redirect). It must serve the new address; an abandoned request has no side effect.

## Timing
- Zero-wait memory (imem_ready in the first REQ cycle): inst_valid rises 1 cycle after the request. Sustained throughput is 1 instruction per 2 cycles when inst_ready=1.
- N wait cycles add N cycles of latency.
- inst_valid is registered; imem_req and imem_addr are decoded from state only.
- After redirect is asserted in cycle t, imem_addr=redirect_pc in cycle t+1.
- halted rises in the cycle after the HALT handshake.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A fetch from an odd PC issues no memory request.
  - The stage presents inst=16'h1000 (ILL_OP opcode 5'b00010, other fields zero) with the normal inst_pc2, one cycle after entering REQ.
- Undefined: PC bit 0 is forced to 0 on imem_addr and fetch proceeds normally. inst_pc2 is still computed from the unmasked PC.

## Structure
- The shared ISA package holds:
  - opcode constants: OP_HALT 5'b00000, OP_NOP 5'b00001, OP_ILL 5'b00010;
  - INST_NOP 16'h0800 and INST_ILL 16'h1000;
  - the fetch state enum.
- One sub-module, `fetch_out_buf`: a 1-entry output register holding inst/inst_pc2/valid, with load, hold, flush and handshake.
- PC register, incrementer and FSM stay in `inst_fetch`.

## Test plan
- Reset, zero-wait memory, program 16'h4101, 16'h4202, inst_ready=1 → imem_addr 0000, 0002; inst_pc2 0002, 0004; inst_valid every other cycle.
- imem_ready delayed 3 cycles → imem_addr held at 0000 for 4 cycles; inst_valid rises on cycle 5.
- inst_ready=0 for 5 cycles → inst and inst_pc2 stable, imem_req=0, no PC advance.
- Redirect to 16'h0040 in the same cycle imem_ready returns → response discarded; next imem_addr=0040; next inst_pc2=0042.
- Fetch 16'h0000 and accept it → halted=1 next cycle, imem_req=0 forever; redirect ignored. Same HALT flushed by a redirect while held → fetch continues.
- PC=16'hFFFE → inst_pc2=0000 and next imem_addr=0000. With FETCH_ALIGN_CHECK_EN, redirect to 0003 → inst=16'h1000, inst_pc2=0005, no imem_req.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared WISC-SP20 ISA constants and fetch-stage types.
package inst_fetch_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_ILL  = 5'b00010;

    localparam logic [15:0] INST_NOP = 16'h0800;
    localparam logic [15:0] INST_ILL = 16'h1000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALT
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] i);
        return i[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry output register for the fetch stage.
// Holds inst/inst_pc2/valid; supports load, hold, flush and handshake.
module fetch_out_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [15:0] load_inst,
    input  logic [15:0] load_pc2,
    output logic [15:0] inst,
    output logic [15:0] inst_pc2,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst     <= INST_NOP;
            inst_pc2 <= 16'h0000;
            valid    <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            inst     <= load_inst;
            inst_pc2 <= load_pc2;
            valid    <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// WISC-SP20 instruction fetch stage: PC, imem requests, decoder handoff.
// Optional FETCH_ALIGN_CHECK_EN turns odd-PC fetches into ILL_OP.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc2,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    fetch_state_e state, state_nxt;
    logic [15:0]  pc, pc_nxt, pc_inc;
    logic [15:0]  resp_inst;
    logic         fetch, resp, flush, load, fire;

    assign pc_inc = pc + 16'd2;
    assign fetch  = (state == REQ);
    assign flush  = redirect && (state != HALT);

`ifdef FETCH_ALIGN_CHECK_EN
    // Odd PC never reaches memory; the stage answers itself with ILL_OP.
    assign imem_req  = fetch && !pc[0];
    assign imem_addr = pc;
    assign resp      = fetch && (pc[0] || imem_ready);
    assign resp_inst = pc[0] ? INST_ILL : imem_rdata;
`else
    assign imem_req  = fetch;
    assign imem_addr = {pc[15:1], 1'b0};
    assign resp      = fetch && imem_ready;
    assign resp_inst = imem_rdata;
`endif

    assign load   = resp && !flush;
    assign fire   = inst_valid && inst_ready && !flush;
    assign halted = (state == HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (flush) begin
            state_nxt = REQ;
            pc_nxt    = redirect_pc;
        end else begin
            unique case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (resp) begin
                        state_nxt = HOLD;
                        pc_nxt    = pc_inc;
                    end
                end
                HOLD: begin
                    if (fire)
                        state_nxt = is_halt(inst) ? HALT : REQ;
                end
                HALT: state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    fetch_out_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .ready     (inst_ready),
        .load_inst (resp_inst),
        .load_pc2  (pc_inc),
        .inst      (inst),
        .inst_pc2  (inst_pc2),
        .valid     (inst_valid)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed stimulus plus a
// transaction-level fetch model checked every falling edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc2;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] mem [0:63];
    int          wait_n = 0;
    int          wcnt = 0;

    inst_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .inst        (inst),
        .inst_pc2    (inst_pc2),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (a < 16'h0080)
            return mem[a[6:1]];
        return 16'h8000 | {1'b0, a[15:1]};
    endfunction

    always_comb imem_rdata = mem_rd(imem_addr);
    assign imem_ready = imem_req && (wcnt >= wait_n);

    always @(posedge clk) begin
        if (!imem_req || imem_ready)
            wcnt <= 0;
        else
            wcnt <= wcnt + 1;
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: next fetch PC, presented instruction, halt status.
    logic [15:0] m_pc, m_inst, m_pc2, p_inst, p_pc2;
    logic        m_valid, m_halt, m_idle, m_want, p_hold;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", inst_valid, 1'b0);
            chk("rst_inst", inst, 16'h0800);
            chk("rst_pc2", inst_pc2, 16'h0000);
            chk("rst_halted", halted, 1'b0);
            m_pc    = 16'h0000;
            m_valid = 1'b0;
            m_halt  = 1'b0;
            m_idle  = 1'b1;
            p_hold  = 1'b0;
        end else begin
            m_want = !m_idle && !m_valid && !m_halt;
            chk("m_halted", halted, m_halt);
            chk("m_valid", inst_valid, m_valid);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("m_req", imem_req, m_want && !m_pc[0]);
            if (imem_req) chk("m_addr", imem_addr, m_pc);
`else
            chk("m_req", imem_req, m_want);
            if (imem_req) chk("m_addr", imem_addr, m_pc & 16'hFFFE);
`endif
            if (m_valid) begin
                chk("m_inst", inst, m_inst);
                chk("m_pc2", inst_pc2, m_pc2);
            end
            if (p_hold) begin
                chk("hold_inst", inst, p_inst);
                chk("hold_pc2", inst_pc2, p_pc2);
            end
            p_hold = inst_valid && !inst_ready && !redirect;
            p_inst = inst;
            p_pc2  = inst_pc2;
            m_idle = 1'b0;
            if (m_halt) begin
                p_hold = 1'b0;
            end else if (redirect) begin
                m_pc    = redirect_pc;
                m_valid = 1'b0;
            end else if (m_valid) begin
                if (inst_ready) begin
                    m_valid = 1'b0;
                    if (m_inst[15:11] == 5'b00000) m_halt = 1'b1;
                end
            end else if (m_want) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (m_pc[0]) begin
                    m_inst  = 16'h1000;
                    m_pc2   = m_pc + 16'd2;
                    m_pc    = m_pc + 16'd2;
                    m_valid = 1'b1;
                end else
`endif
                if (imem_ready) begin
                    m_inst  = mem_rd(m_pc & 16'hFFFE);
                    m_pc2   = m_pc + 16'd2;
                    m_pc    = m_pc + 16'd2;
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        for (int i = 0; i < 64; i++)
            mem[i] = 16'h8000 | 16'(i);
        mem[0]    = 16'h4101;
        mem[1]    = 16'h4202;
        mem[6'h20] = 16'h4120;
        mem[6'h21] = 16'h0000;
        mem[6'h28] = 16'h0000;
        step();
        step();
        rst_n = 1'b1;
        // zero-wait fetch of two instructions
        step();
        chk("t1_req0", imem_req, 1'b1);
        chk("t1_addr0", imem_addr, 16'h0000);
        chk("t1_valid0", inst_valid, 1'b0);
        step();
        chk("t1_valid1", inst_valid, 1'b1);
        chk("t1_inst1", inst, 16'h4101);
        chk("t1_pc2_1", inst_pc2, 16'h0002);
        chk("t1_req1", imem_req, 1'b0);
        step();
        chk("t1_addr2", imem_addr, 16'h0002);
        chk("t1_valid2", inst_valid, 1'b0);
        step();
        chk("t1_inst3", inst, 16'h4202);
        chk("t1_pc2_3", inst_pc2, 16'h0004);
        wait_n = 3;
        // three wait cycles
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_addr", imem_addr, 16'h0004);
            chk("t2_valid", inst_valid, 1'b0);
        end
        wait_n = 0;
        step();
        chk("t2_valid", inst_valid, 1'b1);
        chk("t2_inst", inst, 16'h8002);
        inst_ready = 1'b0;
        // decoder stall
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid", inst_valid, 1'b1);
            chk("t3_inst", inst, 16'h8002);
            chk("t3_pc2", inst_pc2, 16'h0006);
            chk("t3_req", imem_req, 1'b0);
        end
        inst_ready = 1'b1;
        step();
        chk("t4_addr", imem_addr, 16'h0006);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t4_valid", inst_valid, 1'b0);
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr2", imem_addr, 16'h0040);
        step();
        chk("t4_inst", inst, 16'h4120);
        chk("t4_pc2", inst_pc2, 16'h0042);
        step();
        step();
        chk("t5_inst", inst, 16'h0000);
        chk("t5_valid", inst_valid, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0050;
        step();
        redirect = 1'b0;
        chk("t5_nohalt", halted, 1'b0);
        chk("t5_addr", imem_addr, 16'h0050);
        step();
        chk("t5_inst2", inst, 16'h0000);
        chk("t5_pc2", inst_pc2, 16'h0052);
        step();
        chk("t5_halted", halted, 1'b1);
        chk("t5_req", imem_req, 1'b0);
        chk("t5_valid2", inst_valid, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_stay", halted, 1'b1);
            chk("t5_stay_req", imem_req, 1'b0);
        end
        // reset again, redirect from IDLE to the top of memory
        rst_n = 1'b0;
        step();
        chk("t6_rst_inst", inst, 16'h0800);
        chk("t6_rst_halted", halted, 1'b0);
        step();
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("t6_addr", imem_addr, 16'hFFFE);
        step();
        chk("t6_inst", inst, 16'hFFFF);
        chk("t6_pc2", inst_pc2, 16'h0000);
        step();
        chk("t6_wrap", imem_addr, 16'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h0003;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t7_req", imem_req, 1'b0);
        step();
        chk("t7_inst", inst, 16'h1000);
        chk("t7_pc2", inst_pc2, 16'h0005);
`else
        chk("t7_addr", imem_addr, 16'h0002);
        step();
        chk("t7_inst", inst, 16'h4202);
        chk("t7_pc2", inst_pc2, 16'h0005);
`endif
        step();
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
